// File: rtl/mem_wb_stage.sv
// MEM/WB stage of the 5-stage MIPS pipeline.
// Runs loads/stores over a req/ack data-memory handshake, stalls upstream
// while an access is outstanding, and drives the register file write port
// from the registered MEM/WB pipeline register.
module mem_wb_stage #(
    parameter int TIMEOUT = 16   // ACCESS cycles before abort; 0 = wait forever
) (
    input  logic        clk_i,
    input  logic        rst_i,          // asynchronous, active-low
    input  logic        valid_i,
    input  logic        RegWrite_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUres_i,
    input  logic [31:0] RTdata_i,
    input  logic [4:0]  RDaddr_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_err_o,
    output logic        RegWrite_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          rw_q, rw_d;
    logic [4:0]    rda_q, rda_d;
    logic [31:0]   rdd_q, rdd_d;
    // Load destination captured at request time, replayed at the ack edge
    logic          ld_en_q, ld_en_d;
    logic [4:0]    ld_rd_q, ld_rd_d;

    logic memop, aligned, timeout_hit;

    assign memop       = valid_i & (MemRead_i | MemWrite_i);
    assign aligned     = (ALUres_i[1:0] == 2'b00);
    assign timeout_hit = (state_q == ACCESS) && (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Stall is gated by reset so an abandoned access releases upstream at once
    assign stall_o = rst_i & (((state_q == IDLE) & memop & aligned) |
                              ((state_q == ACCESS) & ~mem_ack_i & ~timeout_hit));

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_err_o   = err_q;
    assign RegWrite_o  = rw_q;
    assign RDaddr_o    = rda_q;
    assign RDdata_o    = rdd_q;

    // Next-state and next pipeline-register values; every cycle defaults to a bubble
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_en_d = ld_en_q;
        ld_rd_d = ld_rd_q;
        err_d   = 1'b0;
        rw_d    = 1'b0;
        rda_d   = rda_q;
        rdd_d   = rdd_q;
        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    if (aligned) begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        we_d    = MemWrite_i;
                        addr_d  = ALUres_i;
                        wdata_d = RTdata_i;
                        ld_rd_d = RDaddr_i;
                        // store wins over a simultaneous read: no writeback
                        ld_en_d = RegWrite_i & MemRead_i & ~MemWrite_i & (|RDaddr_i);
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (valid_i) begin
                    rw_d  = RegWrite_i & (|RDaddr_i);
                    rda_d = RDaddr_i;
                    rdd_d = ALUres_i;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rw_d  = ld_en_q;
                        rda_d = ld_rd_q;
                        rdd_d = mem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pipeline registers; reset abandons any in-flight access
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_en_q <= 1'b0;
            ld_rd_q <= '0;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            rda_q   <= '0;
            rdd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_en_q <= ld_en_d;
            ld_rd_q <= ld_rd_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            rda_q   <= rda_d;
            rdd_q   <= rdd_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed test-plan instructions
// followed by random ones, all judged by a transaction-level model.
module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i, RegWrite_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUres_i, RTdata_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_o, RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;

    always #5 clk_i = ~clk_i;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .ALUres_i(ALUres_i),
        .RTdata_i(RTdata_i), .RDaddr_i(RDaddr_i), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .mem_err_o(mem_err_o), .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o),
        .RDdata_o(RDdata_o)
    );

    // k = ACCESS cycle (0-based) in which memory acks; k >= TO means it never does
    typedef struct {
        logic        v, rw, mr, mw;
        logic [31:0] alu, rt, rdata;
        logic [4:0]  rd;
        int          k;
    } instr_t;

    instr_t      dq[$];
    instr_t      cur;
    int          n_chk = 0, n_pass = 0;
    int          p;          // cycles the current instruction has been presented
    bit          consumed;
    bit          exp_rw, exp_err;
    logic [4:0]  exp_rd;
    logic [31:0] exp_dat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic instr_t mk(logic v, logic rw, logic mr, logic mw, logic [31:0] alu,
                                  logic [31:0] rt, logic [4:0] rd, int k, logic [31:0] rdata);
        instr_t t;
        t.v = v; t.rw = rw; t.mr = mr; t.mw = mw; t.alu = alu;
        t.rt = rt; t.rd = rd; t.k = k; t.rdata = rdata;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        int          op;
        logic [31:0] a;
        op = $urandom_range(0, 3);
        a  = $urandom;
        if ($urandom_range(0, 6) != 0) a[1:0] = 2'b00;
        return mk($urandom_range(0, 4) != 0, 1'($urandom), op == 1 || op == 3, op >= 2, a,
                  $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
    endfunction

    task automatic apply(input instr_t t);
        valid_i = t.v; RegWrite_i = t.rw; MemRead_i = t.mr; MemWrite_i = t.mw;
        ALUres_i = t.alu; RTdata_i = t.rt; RDaddr_i = t.rd;
    endtask

    // One clock per iteration: check last edge's results, drive the memory
    // side, predict stall, and work out what the coming edge must produce.
    task automatic run(input int n);
        bit memop, aligned, exp_req, exp_stall;
        int done_idx;
        for (int c = 0; c < n; c++) begin
            @(negedge clk_i);
            chk("regwrite", RegWrite_o, exp_rw);
            if (exp_rw) begin
                chk("rd_addr", RDaddr_o, exp_rd);
                chk("rd_data", RDdata_o, exp_dat);
            end
            chk("mem_err", mem_err_o, exp_err);
            if (consumed) begin
                cur = (dq.size() > 0) ? dq.pop_front() : rand_instr();
                p = 0;
                apply(cur);
            end else p++;
            memop    = cur.v && (cur.mr || cur.mw);
            aligned  = cur.alu[1:0] == 2'b00;
            done_idx = (cur.k < TO) ? cur.k : TO - 1;
            exp_req  = memop && aligned && p >= 1;
            chk("mem_req", mem_req_o, exp_req);
            if (exp_req) begin
                chk("mem_we", mem_we_o, cur.mw);
                chk("mem_addr", mem_addr_o, cur.alu);
                chk("mem_wdata", mem_wdata_o, cur.rt);
            end
            // acks outside an access are noise the stage must ignore
            mem_ack_i   = exp_req ? (p - 1 == cur.k) : ($urandom_range(0, 3) == 0);
            mem_rdata_i = (exp_req && mem_ack_i) ? cur.rdata : $urandom;
            exp_stall   = memop && aligned && !(p >= 1 && p - 1 == done_idx);
            #1 chk("stall", stall_o, exp_stall);
            consumed = !exp_stall;
            exp_rw = 1'b0; exp_err = 1'b0;
            if (consumed && cur.v) begin
                if (!memop) begin
                    exp_rw = cur.rw && cur.rd != 0; exp_rd = cur.rd; exp_dat = cur.alu;
                end else if (!aligned || cur.k >= TO) begin
                    exp_err = 1'b1;
                end else begin
                    exp_rw = cur.rw && cur.mr && !cur.mw && cur.rd != 0;
                    exp_rd = cur.rd; exp_dat = cur.rdata;
                end
            end
        end
    endtask

    initial begin
        int guard;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(cur);
        repeat (2) @(negedge clk_i);
        chk("rst_regwrite", RegWrite_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_err", mem_err_o, 0);
        chk("rst_rdata", RDdata_o, 0);
        chk("rst_stall", stall_o, 0);
        rst_i = 1'b1;
        consumed = 1'b1; exp_rw = 1'b0; exp_err = 1'b0;

        dq.push_back(mk(1, 1, 0, 0, 32'h1234, 0, 5, 0, 0));            // ALU op
        dq.push_back(mk(1, 1, 1, 0, 32'h100, 0, 8, 2, 32'hDEADBEEF));  // load, 3 stall cycles
        dq.push_back(mk(1, 0, 0, 1, 32'h20, 32'hCAFE, 3, 0, 0));       // store, immediate ack
        dq.push_back(mk(1, 1, 1, 0, 32'h40, 0, 0, 1, 32'h1111));       // load to $0
        dq.push_back(mk(1, 1, 1, 0, 32'h102, 0, 3, 0, 0));             // misaligned
        dq.push_back(mk(1, 1, 1, 0, 32'h80, 0, 9, 9, 32'h2222));       // never acked: timeout
        dq.push_back(mk(1, 1, 1, 0, 32'h84, 0, 10, TO - 1, 32'h55AA)); // ack in last cycle
        dq.push_back(mk(1, 1, 1, 1, 32'h88, 32'h77, 7, 1, 32'h3333));  // read+write: store wins
        dq.push_back(mk(1, 1, 0, 0, 32'h99, 0, 0, 0, 0));              // ALU to $0
        dq.push_back(mk(0, 1, 0, 0, 32'h5, 0, 4, 0, 0));               // bubble
        run(40);
        run(600);

        // reset in the middle of an access
        dq.push_back(mk(1, 1, 1, 0, 32'h200, 0, 11, 9, 32'h4444));
        guard = 0;
        while (dq.size() > 0 && guard < 100) begin run(1); guard++; end
        if (dq.size() > 0) chk("sync_timeout", 0, 1);
        run(2);
        chk("pre_rst_req", mem_req_o, 1);
        rst_i = 1'b0;
        #1;
        chk("async_req", mem_req_o, 0);
        chk("async_stall", stall_o, 0);
        chk("async_regwrite", RegWrite_o, 0);
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(cur);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        consumed = 1'b1; exp_rw = 1'b0; exp_err = 1'b0;
        dq.push_back(mk(1, 1, 0, 0, 32'hABCD, 0, 12, 0, 0));
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the 5-stage MIPS pipeline.
- Consumes EX/MEM results and performs loads/stores over a req/ack data-memory handshake.
- Stalls upstream stages while an access is outstanding.
- Drives the register file write port (RegWrite, RDaddr, RDdata) from a registered MEM/WB pipeline register.

Parameters:
TIMEOUT, 16, max cycles ACCESS waits for mem_ack_i before aborting; 0 disables timeout.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
valid_i  input  1  EX/MEM holds a valid instruction
RegWrite_i  input  1  instruction writes a register
MemRead_i  input  1  load word
MemWrite_i  input  1  store word
ALUres_i  input  32  ALU result / memory byte address
RTdata_i  input  32  store data
RDaddr_i  input  5  destination register
stall_o  output  1  combinational; upstream holds all inputs stable while 1
mem_req_o  output  1  memory request, registered
mem_we_o  output  1  1 = write, registered
mem_addr_o  output  32  word-aligned byte address, registered
mem_wdata_o  output  32  store data, registered
mem_ack_i  input  1  memory completes request this cycle
mem_rdata_i  input  32  load data, valid when mem_ack_i=1
mem_err_o  output  1  one-cycle pulse: misaligned access or timeout
RegWrite_o  output  1  register file write enable, registered
RDaddr_o  output  5  register file write address, registered
RDdata_o  output  32  register file write data, registered

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE; all outputs 0; timeout counter 0. Asserting reset mid-ACCESS drops mem_req_o immediately; the in-flight access is abandoned, no writeback.
- States: IDLE, ACCESS.
- memop = valid_i & (MemRead_i | MemWrite_i).
- stall_o = (IDLE & memop & aligned) | (ACCESS & ~mem_ack_i & ~timeout_hit). aligned = (ALUres_i[1:0]==0).
- IDLE, valid non-mem op: next edge loads RegWrite_o = RegWrite_i & (RDaddr_i!=0), RDaddr_o = RDaddr_i, RDdata_o = ALUres_i. Latency 1 cycle.
- IDLE, valid_i=0: next edge loads a bubble (RegWrite_o=0; RDaddr_o/RDdata_o hold).
- IDLE, memop, misaligned: no request; mem_err_o=1 for the next cycle; bubble written; no stall.
- IDLE, memop, aligned:
  - At the next edge: state ACCESS, mem_req_o=1.
  - mem_we_o = MemWrite_i, mem_addr_o = ALUres_i, mem_wdata_o = RTdata_i.
  - Latch RDaddr_i and (RegWrite_i & MemRead_i & RDaddr_i!=0); counter cleared; bubble into WB.
  - If both MemRead_i and MemWrite_i are 1, the store wins and no writeback occurs.
- ACCESS:
  - mem_req_o and its address/data/we are held constant until the ack edge.
  - Each stalled cycle loads a bubble (RegWrite_o=0), so no duplicate writes.
  - Edge with mem_ack_i=1: mem_req_o=0; state IDLE; counter cleared.
    - Load: RegWrite_o = latched enable, RDaddr_o = latched addr, RDdata_o = mem_rdata_i.
    - Store: bubble.
    - stall_o is 0 in the ack cycle, so upstream advances on that same edge. Load-to-register-file latency is 1 cycle after ack.
  - Counter increments each non-ack cycle. When counter == TIMEOUT-1 and TIMEOUT != 0, timeout_hit=1 and at that edge:
    - mem_req_o=0; state IDLE.
    - mem_err_o pulses 1 cycle.
    - Bubble written; stall released.
  - Ack and timeout in the same cycle: ack wins, no error.
- mem_ack_i in IDLE is ignored.
- mem_err_o is 0 in all other cycles.
- The register file bypasses same-cycle writes, so this block needs no additional forwarding.

Test Plan:
1. ALU op: valid_i=1, RegWrite_i=1, RDaddr_i=5, ALUres_i=0x1234 -> one cycle later RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234; stall_o never 1.
2. Load with 3-cycle ack delay: MemRead_i=1, ALUres_i=0x100, RDaddr_i=8 -> stall_o=1 for 3 cycles, then 0 in the ack cycle.
   - Memory side: mem_req_o=1 with mem_addr_o=0x100 until ack.
   - Writeback: mem_rdata_i=0xDEADBEEF, then RegWrite_o=1, RDaddr_o=8, RDdata_o=0xDEADBEEF for exactly one cycle.
   - RegWrite_o=0 throughout the stall.
3. Store: MemWrite_i=1, ALUres_i=0x20, RTdata_i=0xCAFE, immediate ack -> mem_we_o=1, mem_wdata_o=0xCAFE; RegWrite_o stays 0.
4. Load to $0 and misaligned address:
   - Load with RDaddr_i=0 -> access performed, RegWrite_o=0.
   - ALUres_i=0x102 -> no mem_req_o, mem_err_o=1 for one cycle, no stall.
5. Timeout (TIMEOUT=4), never ack -> mem_req_o drops after 4 ACCESS cycles, mem_err_o pulses, stall_o=0, no register write.
   - Ack arriving in the 4th cycle -> normal completion, no error.
6. rst_i=0 mid-ACCESS -> mem_req_o, stall_o, and RegWrite_o go 0 asynchronously.
   - After release, the FSM is in IDLE and a fresh ALU op completes normally.
